// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS32 main control unit: opcodes,
// FSM state encoding and the datapath select codes.
package mips_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpXori = 6'b001110;
  localparam logic [5:0] OpJ    = 6'b000010;

  // FSM states; encodings 13..15 are unused and recover to StFetch
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StIExec   = 4'd9,
    StIWb     = 4'd10,
    StJump    = 4'd11,
    StIllegal = 4'd12
  } state_e;

  // ALU operation codes
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluImm   = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SrcBRt     = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/ctrl_opclass.sv
// Opcode classifier: maps a primary opcode to the state DECODE dispatches to.
module ctrl_opclass
  import mips_ctrl_pkg::*;
#(
  parameter bit EXT_IMM_EN = 1'b1
) (
  input  logic [5:0] opcode,
  output logic [3:0] target
);

  // Dispatch table; anything not decodable lands in the trap state
  always_comb begin
    target = StIllegal;
    case (opcode)
      OpR:                             target = StExec;
      OpLw, OpSw:                      target = StMemAdr;
      OpBeq, OpBne:                    target = StBranch;
      OpAddi:                          target = StIExec;
      OpSlti, OpAndi, OpOri, OpXori:   target = EXT_IMM_EN ? StIExec : StIllegal;
      OpJ:                             target = StJump;
      default:                         target = StIllegal;
    endcase
  end

endmodule

// File: rtl/control_multicycle.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the shared datapath selects, write enables and memory handshake.
module control_multicycle
  import mips_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM   = 1'b1,
  parameter bit EXT_IMM_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_branch_beq,
  output logic       o_branch_bne,
  output logic [1:0] o_pc_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_reg_dst,
  output logic       o_memto_reg,
  output logic       o_reg_write,
  output logic       o_illegal,
  output logic       o_instr_done
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [3:0] dispatch;
  logic       mem_rdy;

  // Without wait states every access completes in the cycle it is issued
  assign mem_rdy = WAIT_MEM ? i_mem_ready : 1'b1;

  ctrl_opclass #(
    .EXT_IMM_EN (EXT_IMM_EN)
  ) u_opclass (
    .opcode (i_opcode),
    .target (dispatch)
  );

  // State and opcode latch with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; opcode is captured only in DECODE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      StFetch:   if (mem_rdy) state_d = StDecode;
      StDecode: begin
        op_d    = i_opcode;
        state_d = state_e'(dispatch);
      end
      StMemAdr:  state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_rdy) state_d = StMemWb;
      StMemWr:   if (mem_rdy) state_d = StFetch;
      StExec:    state_d = StAluWb;
      StIExec:   state_d = StIWb;
      StMemWb,
      StAluWb,
      StIWb,
      StBranch,
      StJump,
      StIllegal: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  // Moore output decode; reset forces every output low in the same cycle
  always_comb begin
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_branch_beq = 1'b0;
    o_branch_bne = 1'b0;
    o_pc_src     = PcSrcAlu;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SrcBRt;
    o_alu_op     = AluAdd;
    o_reg_dst    = 1'b0;
    o_memto_reg  = 1'b0;
    o_reg_write  = 1'b0;
    o_illegal    = 1'b0;
    o_instr_done = 1'b0;
    if (!i_rst) begin
      case (state_q)
        StFetch: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = SrcBFour;
          o_ir_write  = mem_rdy;
          o_pc_write  = mem_rdy;
        end
        StDecode: begin
          o_alu_src_b = SrcBImmSh2;
        end
        StMemAdr: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SrcBImm;
        end
        StMemRd: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        StMemWb: begin
          o_reg_write  = 1'b1;
          o_memto_reg  = 1'b1;
          o_instr_done = 1'b1;
        end
        StMemWr: begin
          o_mem_write  = 1'b1;
          o_iord       = 1'b1;
          o_instr_done = mem_rdy;
        end
        StExec: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SrcBRt;
          o_alu_op    = AluFunct;
        end
        StAluWb: begin
          o_reg_write  = 1'b1;
          o_reg_dst    = 1'b1;
          o_instr_done = 1'b1;
        end
        StIExec: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SrcBImm;
          o_alu_op    = AluImm;
        end
        StIWb: begin
          o_reg_write  = 1'b1;
          o_instr_done = 1'b1;
        end
        StBranch: begin
          o_alu_src_a  = 1'b1;
          o_alu_src_b  = SrcBRt;
          o_alu_op     = AluSub;
          o_pc_src     = PcSrcAluOut;
          o_branch_beq = (op_q == OpBeq);
          o_branch_bne = (op_q == OpBne);
          o_instr_done = 1'b1;
        end
        StJump: begin
          o_pc_src     = PcSrcJump;
          o_pc_write   = 1'b1;
          o_instr_done = 1'b1;
        end
        StIllegal: begin
          o_illegal    = 1'b1;
          o_instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The memory can never see a read and a write in the same cycle
  assert property (@(posedge i_clk) !(o_mem_read && o_mem_write));

endmodule

// File: tb/tb_control_multicycle.sv
// Scoreboard bench for control_multicycle: the driver pushes the hand-derived
// output vector expected for each cycle; the monitor pops and compares it.
module tb_control_multicycle;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       rdy = 1'b1;

  always #5 clk = ~clk;

  // Output vector layout:
  // {mem_read, mem_write, iord, ir_write, pc_write, beq, bne, pc_src[1:0],
  //  src_a, src_b[1:0], alu_op[1:0], reg_dst, memto_reg, reg_write, illegal, done}
  localparam logic [18:0] ZERO       = 19'b0;
  localparam logic [18:0] FETCH_RDY  = {7'b1001100, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000};
  localparam logic [18:0] FETCH_WAIT = {7'b1000000, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000};
  localparam logic [18:0] DECODE     = {7'b0000000, 2'b00, 1'b0, 2'b11, 2'b00, 5'b00000};
  localparam logic [18:0] MEMADR     = {7'b0000000, 2'b00, 1'b1, 2'b10, 2'b00, 5'b00000};
  localparam logic [18:0] MEMRD      = {7'b1010000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00000};
  localparam logic [18:0] MEMWB      = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b01101};
  localparam logic [18:0] MEMWR_RDY  = {7'b0110000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00001};
  localparam logic [18:0] MEMWR_WAIT = {7'b0110000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00000};
  localparam logic [18:0] EXEC       = {7'b0000000, 2'b00, 1'b1, 2'b00, 2'b10, 5'b00000};
  localparam logic [18:0] ALUWB      = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b10101};
  localparam logic [18:0] IEXEC      = {7'b0000000, 2'b00, 1'b1, 2'b10, 2'b11, 5'b00000};
  localparam logic [18:0] IWB        = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00101};
  localparam logic [18:0] BR_BNE     = {7'b0000001, 2'b01, 1'b1, 2'b00, 2'b01, 5'b00001};
  localparam logic [18:0] BR_BEQ     = {7'b0000010, 2'b01, 1'b1, 2'b00, 2'b01, 5'b00001};
  localparam logic [18:0] JUMP       = {7'b0000100, 2'b10, 1'b0, 2'b00, 2'b00, 5'b00001};
  localparam logic [18:0] ILLEGAL    = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00011};

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Three instances: defaults, immediate extension off, wait states off
  logic [18:0] v0, v1, v2;
  logic        mr0, mw0, io0, irw0, pcw0, bq0, bn0, sa0, rd0, m2r0, rw0, il0, dn0;
  logic        mr1, mw1, io1, irw1, pcw1, bq1, bn1, sa1, rd1, m2r1, rw1, il1, dn1;
  logic        mr2, mw2, io2, irw2, pcw2, bq2, bn2, sa2, rd2, m2r2, rw2, il2, dn2;
  logic [1:0]  ps0, sb0, ao0, ps1, sb1, ao1, ps2, sb2, ao2;

  assign v0 = {mr0, mw0, io0, irw0, pcw0, bq0, bn0, ps0, sa0, sb0, ao0, rd0, m2r0, rw0, il0, dn0};
  assign v1 = {mr1, mw1, io1, irw1, pcw1, bq1, bn1, ps1, sa1, sb1, ao1, rd1, m2r1, rw1, il1, dn1};
  assign v2 = {mr2, mw2, io2, irw2, pcw2, bq2, bn2, ps2, sa2, sb2, ao2, rd2, m2r2, rw2, il2, dn2};

  control_multicycle dut (
    .i_clk (clk), .i_rst (rst), .i_opcode (opcode), .i_mem_ready (rdy),
    .o_mem_read (mr0), .o_mem_write (mw0), .o_iord (io0), .o_ir_write (irw0),
    .o_pc_write (pcw0), .o_branch_beq (bq0), .o_branch_bne (bn0), .o_pc_src (ps0),
    .o_alu_src_a (sa0), .o_alu_src_b (sb0), .o_alu_op (ao0), .o_reg_dst (rd0),
    .o_memto_reg (m2r0), .o_reg_write (rw0), .o_illegal (il0), .o_instr_done (dn0)
  );

  control_multicycle #(.WAIT_MEM (1'b1), .EXT_IMM_EN (1'b0)) dut_noext (
    .i_clk (clk), .i_rst (rst), .i_opcode (opcode), .i_mem_ready (rdy),
    .o_mem_read (mr1), .o_mem_write (mw1), .o_iord (io1), .o_ir_write (irw1),
    .o_pc_write (pcw1), .o_branch_beq (bq1), .o_branch_bne (bn1), .o_pc_src (ps1),
    .o_alu_src_a (sa1), .o_alu_src_b (sb1), .o_alu_op (ao1), .o_reg_dst (rd1),
    .o_memto_reg (m2r1), .o_reg_write (rw1), .o_illegal (il1), .o_instr_done (dn1)
  );

  control_multicycle #(.WAIT_MEM (1'b0), .EXT_IMM_EN (1'b1)) dut_nowait (
    .i_clk (clk), .i_rst (rst), .i_opcode (opcode), .i_mem_ready (1'b0),
    .o_mem_read (mr2), .o_mem_write (mw2), .o_iord (io2), .o_ir_write (irw2),
    .o_pc_write (pcw2), .o_branch_beq (bq2), .o_branch_bne (bn2), .o_pc_src (ps2),
    .o_alu_src_a (sa2), .o_alu_src_b (sb2), .o_alu_op (ao2), .o_reg_dst (rd2),
    .o_memto_reg (m2r2), .o_reg_write (rw2), .o_illegal (il2), .o_instr_done (dn2)
  );

  string       q_name[$];
  int          q_which[$];
  logic [18:0] q_exp[$];
  int          checks = 0;
  int          errors = 0;

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input string name, input int which, input logic r,
                      input logic [5:0] op, input logic rd, input logic [18:0] exp);
    @(posedge clk);
    #1;
    rst    = r;
    opcode = op;
    rdy    = rd;
    q_name.push_back(name);
    q_which.push_back(which);
    q_exp.push_back(exp);
  endtask

  // Monitor: compare the selected instance against the queued expectation
  always @(negedge clk) begin : monitor
    string       nm;
    int          w;
    logic [18:0] e;
    logic [18:0] act;
    if (q_exp.size() != 0) begin
      nm  = q_name.pop_front();
      w   = q_which.pop_front();
      e   = q_exp.pop_front();
      act = (w == 0) ? v0 : (w == 1) ? v1 : v2;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b", nm, act, e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    step("reset_outputs", 0, 1'b1, R, 1'b1, ZERO);

    // ADD: 4 cycles
    step("add_fetch",  0, 1'b0, R, 1'b1, FETCH_RDY);
    step("add_decode", 0, 1'b0, R, 1'b1, DECODE);
    step("add_exec",   0, 1'b0, R, 1'b1, EXEC);
    step("add_aluwb",  0, 1'b0, R, 1'b1, ALUWB);

    // LW with two wait cycles in MEMRD: 7 cycles
    step("lw_fetch",   0, 1'b0, LW, 1'b1, FETCH_RDY);
    step("lw_decode",  0, 1'b0, LW, 1'b1, DECODE);
    step("lw_memadr",  0, 1'b0, LW, 1'b1, MEMADR);
    step("lw_memrd_w1",0, 1'b0, LW, 1'b0, MEMRD);
    step("lw_memrd_w2",0, 1'b0, LW, 1'b0, MEMRD);
    step("lw_memrd",   0, 1'b0, LW, 1'b1, MEMRD);
    step("lw_memwb",   0, 1'b0, LW, 1'b1, MEMWB);

    // BNE, opcode changed to BEQ after DECODE
    step("bne_fetch",  0, 1'b0, BNE, 1'b1, FETCH_RDY);
    step("bne_decode", 0, 1'b0, BNE, 1'b1, DECODE);
    step("bne_branch", 0, 1'b0, BEQ, 1'b1, BR_BNE);

    step("beq_fetch",  0, 1'b0, BEQ, 1'b1, FETCH_RDY);
    step("beq_decode", 0, 1'b0, BEQ, 1'b1, DECODE);
    step("beq_branch", 0, 1'b0, BEQ, 1'b1, BR_BEQ);

    // Illegal opcode: single-cycle trap, then FETCH
    step("bad_fetch",  0, 1'b0, BAD, 1'b1, FETCH_RDY);
    step("bad_decode", 0, 1'b0, BAD, 1'b1, DECODE);
    step("bad_trap",   0, 1'b0, BAD, 1'b1, ILLEGAL);

    // J with one FETCH wait cycle
    step("j_fetch_w",  0, 1'b0, J, 1'b0, FETCH_WAIT);
    step("j_fetch",    0, 1'b0, J, 1'b1, FETCH_RDY);
    step("j_decode",   0, 1'b0, J, 1'b1, DECODE);
    step("j_jump",     0, 1'b0, J, 1'b1, JUMP);

    // ORI with immediate extension enabled
    step("ori_fetch",  0, 1'b0, ORI, 1'b1, FETCH_RDY);
    step("ori_decode", 0, 1'b0, ORI, 1'b1, DECODE);
    step("ori_iexec",  0, 1'b0, ORI, 1'b1, IEXEC);
    step("ori_iwb",    0, 1'b0, ORI, 1'b1, IWB);

    // SW with one MEMWR wait cycle
    step("sw_fetch",   0, 1'b0, SW, 1'b1, FETCH_RDY);
    step("sw_decode",  0, 1'b0, SW, 1'b1, DECODE);
    step("sw_memadr",  0, 1'b0, SW, 1'b1, MEMADR);
    step("sw_memwr_w", 0, 1'b0, SW, 1'b0, MEMWR_WAIT);
    step("sw_memwr",   0, 1'b0, SW, 1'b1, MEMWR_RDY);

    // Reset in MEMWR with ready high aborts the store
    step("rsw_fetch",  0, 1'b0, SW, 1'b1, FETCH_RDY);
    step("rsw_decode", 0, 1'b0, SW, 1'b1, DECODE);
    step("rsw_memadr", 0, 1'b0, SW, 1'b1, MEMADR);
    step("rsw_reset",  0, 1'b1, SW, 1'b1, ZERO);
    step("rsw_refetch",0, 1'b0, SW, 1'b1, FETCH_RDY);

    // EXT_IMM_EN=0: ORI traps
    step("ne_reset",   1, 1'b1, ORI, 1'b1, ZERO);
    step("ne_fetch",   1, 1'b0, ORI, 1'b1, FETCH_RDY);
    step("ne_decode",  1, 1'b0, ORI, 1'b1, DECODE);
    step("ne_trap",    1, 1'b0, ORI, 1'b1, ILLEGAL);
    step("ne_refetch", 1, 1'b0, ORI, 1'b1, FETCH_RDY);

    // WAIT_MEM=0 with ready tied low: SW in 4 cycles
    step("nw_reset",   2, 1'b1, SW, 1'b0, ZERO);
    step("nw_fetch",   2, 1'b0, SW, 1'b0, FETCH_RDY);
    step("nw_decode",  2, 1'b0, SW, 1'b0, DECODE);
    step("nw_memadr",  2, 1'b0, SW, 1'b0, MEMADR);
    step("nw_memwr",   2, 1'b0, SW, 1'b0, MEMWR_RDY);
    step("nw_refetch", 2, 1'b0, SW, 1'b0, FETCH_RDY);

    repeat (2) @(posedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_multicycle.md
# control_multicycle

Multicycle main control unit for the MIPS32 core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps over several clocks. It drives the shared datapath's mux selects, register/PC/IR write enables, and a ready/valid memory handshake. It replaces the single-cycle opcode decoder and adds:
- memory wait states;
- an opcode latch;
- illegal-opcode trapping, with no X outputs in any state;
- a parametrised immediate-instruction set.

## Interface
- `WAIT_MEM`, default 1: 1 = memory states hold until `i_mem_ready`; 0 = `i_mem_ready` is ignored and treated as 1.
- `EXT_IMM_EN`, default 1: 1 = SLTI/ANDI/ORI/XORI are decoded; 0 = those opcodes trap as illegal.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_opcode`  in  6  instr[31:26] from the IR.
- `i_mem_ready`  in  1  memory completes the current access this cycle.
- `o_mem_read`, `o_mem_write`  out  1  memory request strobes.
- `o_iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `o_ir_write`, `o_pc_write`  out  1  IR and PC load enables.
- `o_branch_beq`, `o_branch_bne`  out  1  conditional PC write: PC loads on ALU zero (BEQ) or on ALU not-zero (BNE).
- `o_pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `o_alu_src_a`  out  1  ALU A: 0 = PC, 1 = rs.
- `o_alu_src_b`  out  2  ALU B: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `o_alu_op`  out  2  ALU op: 00 = add, 01 = sub, 10 = funct, 11 = opcode-immediate.
- `o_reg_dst`, `o_memto_reg`, `o_reg_write`  out  1  register-file write controls.
- `o_illegal`  out  1  one-cycle pulse on an undecodable opcode.
- `o_instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.

## Operation
- State register: 4 bits. Every output is a function of state; the only exception is the `i_mem_ready` gating described below.
- Unlisted outputs are 0 in every state. No output is ever X.
- FETCH
  - Outputs: `mem_read`=1, `iord`=0, `src_a`=0, `src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` = `i_mem_ready`.
  - Holds while ready is 0; goes to DECODE when ready is 1.
- DECODE
  - Outputs: `src_a`=0, `src_b`=11, `alu_op`=00.
  - Latches `i_opcode` into `op_q`.
  - Dispatch: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 or 000101 → BRANCH; 001000 → IEXEC; 001010/001100/001101/001110 → IEXEC when `EXT_IMM_EN`, else ILLEGAL; 000010 → JUMP; anything else → ILLEGAL.
- MEMADR: `src_a`=1, `src_b`=10, `alu_op`=00. Goes to MEMRD if `op_q` is LW, else MEMWR.
- MEMRD: `mem_read`=1, `iord`=1. Holds until ready, then goes to MEMWB.
- MEMWB: `reg_write`=1, `memto_reg`=1, `reg_dst`=0, `instr_done`=1. Goes to FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Holds until ready. `instr_done` = `i_mem_ready`. Goes to FETCH.
- EXEC: `src_a`=1, `src_b`=00, `alu_op`=10. Goes to ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `instr_done`=1. Goes to FETCH.
- IEXEC: `src_a`=1, `src_b`=10, `alu_op`=11. Goes to IWB.
- IWB: `reg_write`=1, `reg_dst`=0, `instr_done`=1. Goes to FETCH.
- BRANCH
  - Outputs: `src_a`=1, `src_b`=00, `alu_op`=01, `pc_src`=01, `instr_done`=1.
  - `branch_beq` = (`op_q`==BEQ); `branch_bne` = (`op_q`==BNE).
  - Goes to FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1. Goes to FETCH.
- ILLEGAL: `illegal`=1, `instr_done`=1. Goes to FETCH; the PC has already advanced, so the instruction is skipped.
- Memory request strobes stay asserted, with stable `iord`, for every wait cycle. `mem_read` and `mem_write` are never high together.

## Timing
- Latency with ready=1 throughout, counted from FETCH entry to FETCH re-entry: R 4, I-ALU 4, LW 5, SW 4, BEQ/BNE 3, J 3, ILLEGAL 3.
- Each cycle with `i_mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `i_opcode` is sampled only in DECODE. Later opcode changes do not affect the sequence.
- Reset:
  - During any cycle with `i_rst`=1, all enables and strobes are forced to 0: `mem_read`, `mem_write`, `ir_write`, `pc_write`, `reg_write`, both branch outputs, `illegal`, `instr_done`.
  - All selects are driven to 0.
  - After the edge: state = FETCH, `op_q` = 0.
  - Reset in any state, including wait states, aborts the instruction with no write issued.
- Reset dominates a simultaneous `i_mem_ready`.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode localparams (R, LW, SW, BEQ, BNE, ADDI, SLTI, ANDI, ORI, XORI, J);
  - the state encoding enum (FETCH=0 … ILLEGAL=12);
  - the `alu_op` and `src_b`/`pc_src` code constants.
- One sub-module, `ctrl_opclass`, is combinational: it maps an opcode and `EXT_IMM_EN` to a dispatch target state, and DECODE uses it.
- The top level contains the state register, `op_q`, and the output decode.

## Test plan
- ADD (000000), ready=1 → 4 cycles. ALUWB has `reg_write`=1 and `reg_dst`=1. EXEC has `alu_op`=10. `instr_done` pulses once.
- LW (100011) with ready=0 for 2 cycles in MEMRD → 7 cycles total. `mem_read`=1 and `iord`=1 throughout the wait. MEMWB has `memto_reg`=1.
- BNE (000101), with `i_opcode` changed to 000100 after DECODE → BRANCH drives `branch_bne`=1, `branch_beq`=0, `pc_src`=01.
- Opcode 111111 → FETCH, DECODE, ILLEGAL (`o_illegal`=1 for exactly 1 cycle), then FETCH.
- `EXT_IMM_EN`=0 with ORI (001101) → ILLEGAL. `EXT_IMM_EN`=1 with ORI → IEXEC (`alu_op`=11, `src_b`=10), then IWB with `reg_write`=1.
- Reset asserted in MEMWR with ready=1 → `mem_write`=0 that cycle. The next cycle is FETCH with `mem_read`=1. `WAIT_MEM`=0 with ready tied to 0 → SW completes in 4 cycles.
